// File: rtl/sdram_request_queue.sv
// In-order request queue in front of sdram_controller: FIFO-buffered client requests are issued
// one at a time with the enable-until-busy handshake; read data returns through a one-entry register.
module sdram_request_queue #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_err,
    output logic [ADDR_W-1:0]             ctl_wr_addr,
    output logic [DATA_W-1:0]             ctl_wr_data,
    output logic                          ctl_wr_enable,
    output logic [ADDR_W-1:0]             ctl_rd_addr,
    output logic                          ctl_rd_enable,
    input  logic [DATA_W-1:0]             ctl_rd_data,
    input  logic                          ctl_rd_ready,
    input  logic                          ctl_busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          err_timeout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nxt;
    req_t              fifo_mem [FIFO_DEPTH];
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [TMR_W-1:0]  timer;
    logic              cur_write;
    logic              cap_vld;
    logic [DATA_W-1:0] cap_data;

    logic push, pop, drop, abort, complete;
    logic can_issue, timed_out, rd_hit, done;

    assign req_ready = (pending != (PTR_W + 1)'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = fifo_mem[rd_ptr];
    // A read may only start when the response slot is free; writes never wait on it.
    assign can_issue = (pending != '0) && (head.write || !resp_valid);
    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));
    assign rd_hit    = ctl_rd_ready && !cur_write;
    assign done      = !ctl_busy && (cur_write || cap_vld || rd_hit);

    // FIFO storage and occupancy
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, data: req_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (can_issue) state_nxt = ISSUE;
            ISSUE: begin
                if (timed_out)     state_nxt = IDLE;
                else if (ctl_busy) state_nxt = WAIT;
            end
            WAIT:  if (done || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: per-cycle actions; a normal completion wins over a timeout landing on the same cycle
    always_comb begin
        pop      = 1'b0;
        drop     = 1'b0;
        abort    = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE:  pop = can_issue;
            ISSUE: begin
                abort = timed_out;
                drop  = ctl_busy || timed_out;
            end
            WAIT:  begin
                complete = done;
                abort    = !done && timed_out;
                drop     = abort;
            end
            default: ;
        endcase
    end

    // Controller command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_wr_addr   <= '0;
            ctl_wr_data   <= '0;
            ctl_wr_enable <= 1'b0;
            ctl_rd_addr   <= '0;
            ctl_rd_enable <= 1'b0;
            cur_write     <= 1'b0;
        end else if (pop) begin
            cur_write <= head.write;
            if (head.write) begin
                ctl_wr_addr   <= head.addr;
                ctl_wr_data   <= head.data;
                ctl_wr_enable <= 1'b1;
            end else begin
                ctl_rd_addr   <= head.addr;
                ctl_rd_enable <= 1'b1;
            end
        end else if (drop) begin
            ctl_wr_addr   <= '0;
            ctl_wr_data   <= '0;
            ctl_wr_enable <= 1'b0;
            ctl_rd_addr   <= '0;
            ctl_rd_enable <= 1'b0;
        end
    end

    // Watchdog timer and read data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            cap_vld  <= 1'b0;
            cap_data <= '0;
        end else begin
            if (pop)                 timer <= '0;
            else if (state != IDLE)  timer <= timer + 1'b1;
            if (pop) begin
                cap_vld <= 1'b0;
            end else if (state != IDLE && rd_hit) begin
                cap_vld  <= 1'b1;
                cap_data <= ctl_rd_data;
            end
        end
    end

    // Response register: a new load takes priority over the consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (complete && !cur_write) begin
                resp_valid <= 1'b1;
                resp_data  <= rd_hit ? ctl_rd_data : cap_data;
                resp_err   <= 1'b0;
            end else if (abort && !cur_write) begin
                resp_valid <= 1'b1;
                resp_data  <= '0;
                resp_err   <= 1'b1;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (abort) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_request_queue.sv
// Bench for sdram_request_queue: table-driven requests, command/response scoreboards,
// and a small behavioural controller (busy 2 cycles after enable, 8 busy cycles, rd_ready on busy cycle 6).
module tb_sdram_request_queue;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [24:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_data;
    logic [24:0] ctl_wr_addr, ctl_rd_addr;
    logic [15:0] ctl_wr_data, ctl_rd_data;
    logic        ctl_wr_enable, ctl_rd_enable, ctl_rd_ready, ctl_busy;
    logic [2:0]  pending;
    logic        err_timeout;

    sdram_request_queue #(.ADDR_W(25), .DATA_W(16), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data), .ctl_wr_enable(ctl_wr_enable),
        .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable), .ctl_rd_data(ctl_rd_data),
        .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy),
        .pending(pending), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model
    logic        mode_never, mode_coinc;
    int          m_st, m_cnt;
    logic        m_w;
    logic [24:0] m_a;
    logic [15:0] m_d;
    logic [15:0] mem [0:255];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_busy <= 1'b0; ctl_rd_ready <= 1'b0; ctl_rd_data <= '0;
            m_st <= 0; m_cnt <= 0; m_w <= 1'b0; m_a <= '0; m_d <= '0;
        end else begin
            ctl_rd_ready <= 1'b0;
            case (m_st)
                0: if (!mode_never && (ctl_wr_enable || ctl_rd_enable)) begin
                    m_st <= 1;
                    m_w  <= ctl_wr_enable;
                    m_a  <= ctl_wr_enable ? ctl_wr_addr : ctl_rd_addr;
                    m_d  <= ctl_wr_data;
                end
                1: begin
                    m_st <= 2; ctl_busy <= 1'b1; m_cnt <= 1;
                    if (m_w) mem[m_a[7:0]] <= m_d;
                end
                default: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 5 && !m_w && !mode_coinc) begin
                        ctl_rd_ready <= 1'b1; ctl_rd_data <= mem[m_a[7:0]];
                    end
                    if (m_cnt == 8) begin
                        ctl_busy <= 1'b0; m_st <= 0;
                        if (!m_w && mode_coinc) begin
                            ctl_rd_ready <= 1'b1; ctl_rd_data <= mem[m_a[7:0]];
                        end
                    end
                end
            endcase
        end
    end

    typedef struct { logic w; logic [24:0] a; logic [15:0] d; } cmd_t;
    typedef struct { logic [15:0] d; logic e; } rsp_t;
    typedef struct { logic w; logic [24:0] a; logic [15:0] wd; logic [15:0] exp; } vec_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   nchk, nfail, exp_en_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Entered and left at posedge+1; leaves req_valid high so calls can be chained back to back
    task automatic push(input logic w, input logic [24:0] a, input logic [15:0] d,
                        input logic [15:0] ed, input logic ee);
        int t = 0;
        while (!req_ready && t < 200) begin step(); t++; end
        if (t >= 200) chk("push_timeout", 32'(req_ready), 32'(1));
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        cmd_q.push_back('{w: w, a: a, d: d});
        if (!w) rsp_q.push_back('{d: ed, e: ee});
        step();
    endtask

    task automatic wait_quiet();
        int t = 0, q = 0;
        while (q < 3 && t < 400) begin
            step(); t++;
            if (!ctl_wr_enable && !ctl_rd_enable && !ctl_busy && pending == 0 && m_st == 0 &&
                !resp_valid && rsp_q.size() == 0 && cmd_q.size() == 0) q++;
            else q = 0;
        end
        if (q < 3) chk("quiet_timeout", 32'(t), 32'(0));
    endtask

    task automatic wait_sig(input string name, input int which);
        int t = 0;
        while (t < 200 && !((which == 0 && ctl_rd_enable) || (which == 1 && ctl_busy) ||
                            (which == 2 && !ctl_busy) || (which == 3 && resp_valid) ||
                            (which == 4 && (ctl_wr_enable || ctl_rd_enable)))) begin
            step(); t++;
        end
        if (t >= 200) chk(name, 32'(t), 32'(0));
    endtask

    vec_t vecs[7];
    logic        prev_en, prev_busy, prev_push, prev_rv, en;
    logic [24:0] prev_addr, cur_addr;
    int          pend_m, en_len, cnt;
    cmd_t        c;
    rsp_t        r;

    initial begin
        nchk = 0; nfail = 0; exp_en_len = 3;
        mode_never = 1'b0; mode_coinc = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        prev_en = 0; prev_busy = 0; prev_push = 0; prev_rv = 0; prev_addr = '0;
        pend_m = 0; en_len = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        vecs[0] = '{1'b1, 25'h0000000, 16'h3D1A, 16'h0000};
        vecs[1] = '{1'b0, 25'h0000000, 16'h0000, 16'h3D1A};
        vecs[2] = '{1'b1, 25'h1FFFFFF, 16'hFFFF, 16'h0000};
        vecs[3] = '{1'b0, 25'h1FFFFFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{1'b1, 25'h0000123, 16'h0001, 16'h0000};
        vecs[5] = '{1'b0, 25'h0000123, 16'h0000, 16'h0001};
        vecs[6] = '{1'b0, 25'h0000000, 16'h0000, 16'h3D1A};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_wr_en", 32'(ctl_wr_enable), 32'(0));
        chk("rst_rd_en", 32'(ctl_rd_enable), 32'(0));
        chk("rst_wr_addr", 32'(ctl_wr_addr), 32'(0));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_resp_data", 32'(resp_data), 32'(0));
        chk("rst_resp_err", 32'(resp_err), 32'(0));
        chk("rst_err_timeout", 32'(err_timeout), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Monitor: command order, handshake shape, occupancy and response scoreboard
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_en = 0; prev_busy = 0; prev_push = 0; prev_rv = 0; en_len = 0; pend_m = 0;
                end else begin
                    en = ctl_wr_enable | ctl_rd_enable;
                    cur_addr = ctl_wr_enable ? ctl_wr_addr : ctl_rd_addr;
                    if (en && !prev_en) begin
                        pend_m--;
                        if (cmd_q.size() == 0) chk("unexpected_cmd", 32'(cmd_q.size()), 32'(1));
                        else begin
                            c = cmd_q.pop_front();
                            chk("cmd_is_write", 32'(ctl_wr_enable), 32'(c.w));
                            chk("cmd_addr", 32'(cur_addr), 32'(c.a));
                            if (c.w) chk("cmd_wdata", 32'(ctl_wr_data), 32'(c.d));
                            else     chk("rd_issue_resp_free", 32'(prev_rv), 32'(0));
                        end
                    end
                    if (prev_en && en) chk("cmd_addr_stable", 32'(cur_addr), 32'(prev_addr));
                    if (prev_en && prev_busy) chk("en_drop_on_busy", 32'(en), 32'(0));
                    if (en) en_len++;
                    else if (prev_en) begin
                        if (exp_en_len != 0) chk("en_len", 32'(en_len), 32'(exp_en_len));
                        en_len = 0;
                    end
                    if (prev_push) pend_m++;
                    chk("pending", 32'(pending), 32'(pend_m));
                    chk("req_ready", 32'(req_ready), 32'(pend_m != 4));
                    if (resp_valid && resp_ready) begin
                        if (rsp_q.size() == 0) chk("unexpected_resp", 32'(rsp_q.size()), 32'(1));
                        else begin
                            r = rsp_q.pop_front();
                            chk("resp_data", 32'(resp_data), 32'(r.d));
                            chk("resp_err", 32'(resp_err), 32'(r.e));
                        end
                    end
                    prev_en = en; prev_busy = ctl_busy; prev_addr = cur_addr;
                    prev_push = req_valid && req_ready; prev_rv = resp_valid;
                end
            end
        join_none

        // Table of writes/reads, including the all-ones address
        step();
        foreach (vecs[i]) push(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp, 1'b0);
        req_valid = 1'b0;
        wait_quiet();

        // FIFO fills behind an in-flight command; 5th push waits for space
        push(1'b1, 25'h100, 16'h5555, 16'h0, 1'b0);
        req_valid = 1'b0;
        wait_sig("wait_first_issue", 4);
        push(1'b1, 25'h101, 16'h1111, 16'h0, 1'b0);
        push(1'b0, 25'h100, 16'h0, 16'h5555, 1'b0);
        push(1'b1, 25'h102, 16'h2222, 16'h0, 1'b0);
        push(1'b0, 25'h101, 16'h0, 16'h1111, 1'b0);
        chk("full_pending", 32'(pending), 32'(4));
        chk("full_req_ready", 32'(req_ready), 32'(0));
        push(1'b0, 25'h102, 16'h0, 16'h2222, 1'b0);
        req_valid = 1'b0;
        wait_quiet();

        // Held response stalls the next read
        push(1'b1, 25'h10, 16'hAAAA, 16'h0, 1'b0);
        push(1'b1, 25'h20, 16'hBBBB, 16'h0, 1'b0);
        req_valid = 1'b0;
        wait_quiet();
        resp_ready = 1'b0;
        push(1'b0, 25'h10, 16'h0, 16'hAAAA, 1'b0);
        push(1'b0, 25'h20, 16'h0, 16'hBBBB, 1'b0);
        req_valid = 1'b0;
        wait_sig("wait_resp1", 3);
        cnt = 0;
        repeat (20) begin step(); if (ctl_rd_enable) cnt++; end
        chk("read_stall", 32'(cnt), 32'(0));
        chk("held_resp_data", 32'(resp_data), 32'hAAAA);
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        wait_sig("wait_resp2", 3);
        chk("second_resp_data", 32'(resp_data), 32'hBBBB);
        resp_ready = 1'b1;
        wait_quiet();

        // Controller never goes busy: watchdog abort
        mode_never = 1'b1; exp_en_len = 16;
        chk("err_timeout_before", 32'(err_timeout), 32'(0));
        push(1'b0, 25'h30, 16'h0, 16'h0000, 1'b1);
        req_valid = 1'b0;
        wait_quiet();
        chk("err_timeout_set", 32'(err_timeout), 32'(1));
        mode_never = 1'b0; exp_en_len = 3;
        push(1'b1, 25'h31, 16'h7777, 16'h0, 1'b0);
        push(1'b0, 25'h31, 16'h0, 16'h7777, 1'b0);
        req_valid = 1'b0;
        wait_quiet();
        chk("err_timeout_sticky", 32'(err_timeout), 32'(1));

        // rd_ready in the same cycle busy falls
        mode_coinc = 1'b1;
        push(1'b1, 25'h50, 16'h1234, 16'h0, 1'b0);
        push(1'b0, 25'h50, 16'h0, 16'h1234, 1'b0);
        req_valid = 1'b0;
        wait_sig("coinc_rd_en", 0);
        wait_sig("coinc_busy_hi", 1);
        wait_sig("coinc_busy_lo", 2);
        chk("coinc_rd_ready", 32'(ctl_rd_ready), 32'(1));
        chk("coinc_not_early", 32'(resp_valid), 32'(0));
        step();
        chk("coinc_resp_valid", 32'(resp_valid), 32'(1));
        chk("coinc_resp_data", 32'(resp_data), 32'h1234);
        wait_quiet();
        mode_coinc = 1'b0;

        // Asynchronous reset during the WAIT of a read
        push(1'b0, 25'h60, 16'h0, 16'h0, 1'b0);
        push(1'b1, 25'h61, 16'h4321, 16'h0, 1'b0);
        push(1'b0, 25'h61, 16'h0, 16'h4321, 1'b0);
        req_valid = 1'b0;
        wait_sig("rst_rd_en", 0);
        wait_sig("rst_busy", 1);
        step(); step();
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(ctl_wr_enable), 32'(0));
        chk("arst_rd_en", 32'(ctl_rd_enable), 32'(0));
        chk("arst_pending", 32'(pending), 32'(0));
        chk("arst_req_ready", 32'(req_ready), 32'(1));
        chk("arst_err_timeout", 32'(err_timeout), 32'(0));
        cmd_q.delete(); rsp_q.delete();
        step(); step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin step(); if (resp_valid || ctl_rd_enable || ctl_wr_enable) cnt++; end
        chk("post_rst_idle", 32'(cnt), 32'(0));
        push(1'b1, 25'h70, 16'hBEEF, 16'h0, 1'b0);
        push(1'b0, 25'h70, 16'h0, 16'hBEEF, 1'b0);
        req_valid = 1'b0;
        wait_quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
